// File: rtl/gsf_forward_unit.sv
`default_nettype none
// ============================================================================
// Module  : gsf_forward_unit
// Purpose : group store-and-forward ring buffer with a first-word-fall-through
//           read port; groups become readable only once fully written.
// Option  : define GSF_STATS_EN to build the commit/consume statistics counters
// Rev     : 1.0
// ============================================================================
module gsf_forward_unit #(
    parameter int DATA_W       = 16,
    parameter int LANES        = 1,
    parameter int GROUP_WORDS  = 32,
    parameter int DEPTH_GROUPS = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                flush,
    input  logic                                wr_valid,
    input  logic [LANES*DATA_W-1:0]             wr_data,
    input  logic                                wr_last,
    output logic                                rd_valid,
    input  logic                                rd_ready,
    output logic [LANES*DATA_W-1:0]             rd_data,
    output logic                                rd_last,
    output logic                                credit_available,
    output logic [$clog2(DEPTH_GROUPS+1)-1:0]   group_count,
    output logic                                group_consumed,
    output logic                                error,
    output logic [1:0]                          error_code,
    output logic [15:0]                         stat_groups_in,
    output logic [15:0]                         stat_groups_out
);

    localparam int c_word_w = LANES * DATA_W;
    localparam int c_slot_w = (DEPTH_GROUPS > 1) ? $clog2(DEPTH_GROUPS) : 1;
    localparam int c_idx_w  = (GROUP_WORDS > 1) ? $clog2(GROUP_WORDS) : 1;
    localparam int c_len_w  = $clog2(GROUP_WORDS + 1);
    localparam int c_cnt_w  = $clog2(DEPTH_GROUPS + 1);

    localparam logic [c_slot_w-1:0] c_last_slot = c_slot_w'(DEPTH_GROUPS - 1);
    localparam logic [c_len_w-1:0]  c_full_len  = c_len_w'(GROUP_WORDS);
    localparam logic [c_len_w-1:0]  c_one_len   = c_len_w'(1);
    localparam logic [c_cnt_w-1:0]  c_depth     = c_cnt_w'(DEPTH_GROUPS);

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_FILL = 2'd1,
        WR_DROP = 2'd2
    } wr_state_e;

    wr_state_e              wr_state_q, wr_state_d;
    logic [c_slot_w-1:0]    wr_slot_q, wr_slot_d;
    logic [c_slot_w-1:0]    rd_slot_q, rd_slot_d;
    logic [c_len_w-1:0]     wr_idx_q, wr_idx_d;
    logic [c_idx_w-1:0]     rd_idx_q, rd_idx_d;
    logic                   drop_commit_q, drop_commit_d;
    logic [c_cnt_w-1:0]     occ_q, occ_d;
    logic [c_cnt_w-1:0]     gcount_q, gcount_d;
    logic [1:0]             err_q, err_d;
    logic                   consumed_q;
    logic [c_len_w-1:0]     len_q [DEPTH_GROUPS];
    logic [c_word_w-1:0]    mem_q [DEPTH_GROUPS][GROUP_WORDS];

    logic                   w_mem_we;
    logic                   w_commit;
    logic                   w_first;
    logic                   w_fire;
    logic                   w_consume;
    logic [c_len_w-1:0]     w_commit_len;
    logic [c_len_w-1:0]     w_rd_len;

    function automatic logic [c_slot_w-1:0] f_next_slot(input logic [c_slot_w-1:0] s);
        return (s == c_last_slot) ? '0 : s + 1'b1;
    endfunction

    // Read side: the head committed group is presented fall-through.
    assign w_rd_len         = len_q[rd_slot_q];
    assign rd_valid         = (gcount_q != '0);
    assign rd_data          = mem_q[rd_slot_q][rd_idx_q];
    assign rd_last          = rd_valid && ((c_len_w'(rd_idx_q) + 1'b1) == w_rd_len);
    assign w_fire           = rd_valid && rd_ready;
    assign w_consume        = w_fire && rd_last;
    assign credit_available = (occ_q < c_depth);
    assign group_count      = gcount_q;
    assign group_consumed   = consumed_q;
    assign error_code       = err_q;
    assign error            = |err_q;

    always_comb begin
        wr_state_d    = wr_state_q;
        wr_slot_d     = wr_slot_q;
        wr_idx_d      = wr_idx_q;
        drop_commit_d = drop_commit_q;
        err_d         = err_q;
        w_mem_we      = 1'b0;
        w_commit      = 1'b0;
        w_first       = 1'b0;
        w_commit_len  = c_one_len;
        case (wr_state_q)
            WR_IDLE: begin
                if (wr_valid) begin
                    if (credit_available) begin
                        w_first  = 1'b1;
                        w_mem_we = 1'b1;
                        if (wr_last) begin
                            w_commit = 1'b1;
                        end else begin
                            wr_idx_d   = c_one_len;
                            wr_state_d = WR_FILL;
                        end
                    end else begin
                        err_d[0] = 1'b1;
                        // A dropped single-word group is already complete.
                        if (!wr_last) begin
                            drop_commit_d = 1'b0;
                            wr_state_d    = WR_DROP;
                        end
                    end
                end
            end
            WR_FILL: begin
                if (wr_valid) begin
                    if (wr_idx_q == c_full_len) begin
                        err_d[1] = 1'b1;
                        if (wr_last) begin
                            w_commit     = 1'b1;
                            w_commit_len = c_full_len;
                        end else begin
                            drop_commit_d = 1'b1;
                            wr_state_d    = WR_DROP;
                        end
                    end else begin
                        w_mem_we = 1'b1;
                        if (wr_last) begin
                            w_commit     = 1'b1;
                            w_commit_len = wr_idx_q + 1'b1;
                        end else begin
                            wr_idx_d = wr_idx_q + 1'b1;
                        end
                    end
                end
            end
            WR_DROP: begin
                if (wr_valid && wr_last) begin
                    w_commit      = drop_commit_q;
                    w_commit_len  = c_full_len;
                    drop_commit_d = 1'b0;
                    wr_state_d    = WR_IDLE;
                end
            end
            default: begin
                wr_state_d = WR_IDLE;
            end
        endcase
        if (w_commit) begin
            wr_slot_d     = f_next_slot(wr_slot_q);
            wr_idx_d      = '0;
            drop_commit_d = 1'b0;
            wr_state_d    = WR_IDLE;
        end
    end

    always_comb begin
        rd_idx_d  = rd_idx_q;
        rd_slot_d = rd_slot_q;
        gcount_d  = gcount_q;
        occ_d     = occ_q;
        if (w_consume) begin
            rd_idx_d  = '0;
            rd_slot_d = f_next_slot(rd_slot_q);
        end else if (w_fire) begin
            rd_idx_d = rd_idx_q + 1'b1;
        end
        // Commit and consume in one cycle cancel out on the group count.
        if (w_commit && !w_consume) begin
            gcount_d = gcount_q + 1'b1;
        end else if (!w_commit && w_consume) begin
            gcount_d = gcount_q - 1'b1;
        end
        if (w_first && !w_consume) begin
            occ_d = occ_q + 1'b1;
        end else if (!w_first && w_consume) begin
            occ_d = occ_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_state_q    <= WR_IDLE;
            wr_slot_q     <= '0;
            rd_slot_q     <= '0;
            wr_idx_q      <= '0;
            rd_idx_q      <= '0;
            drop_commit_q <= 1'b0;
            occ_q         <= '0;
            gcount_q      <= '0;
            err_q         <= 2'b00;
            consumed_q    <= 1'b0;
            for (int i = 0; i < DEPTH_GROUPS; i++) begin
                len_q[i] <= '0;
            end
        end else begin
            wr_state_q    <= wr_state_d;
            wr_slot_q     <= wr_slot_d;
            rd_slot_q     <= rd_slot_d;
            wr_idx_q      <= wr_idx_d;
            rd_idx_q      <= rd_idx_d;
            drop_commit_q <= drop_commit_d;
            occ_q         <= occ_d;
            gcount_q      <= gcount_d;
            err_q         <= err_d;
            consumed_q    <= w_consume;
            if (w_commit) begin
                len_q[wr_slot_q] <= w_commit_len;
            end
        end
    end

    // Data storage carries no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem_q[wr_slot_q][wr_idx_q[c_idx_w-1:0]] <= wr_data;
        end
    end

`ifdef GSF_STATS_EN
    logic [15:0] stat_in_q;
    logic [15:0] stat_out_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_in_q  <= 16'd0;
            stat_out_q <= 16'd0;
        end else begin
            if (w_commit && !flush) begin
                stat_in_q <= stat_in_q + 16'd1;
            end
            if (consumed_q) begin
                stat_out_q <= stat_out_q + 16'd1;
            end
        end
    end

    assign stat_groups_in  = stat_in_q;
    assign stat_groups_out = stat_out_q;
`else
    assign stat_groups_in  = 16'd0;
    assign stat_groups_out = 16'd0;
`endif

endmodule
`default_nettype wire

// File: doc/gsf_forward_unit.md
GSF_FORWARD_UNIT -- requirements
Module: gsf_forward_unit

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DATA_W, 16, lane width in bits.
- LANES, 1, lanes per word; the word width is LANES*DATA_W.
- GROUP_WORDS, 32, maximum words per group.
- DEPTH_GROUPS, 2, number of group slots (≥1).
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, the single clock.
- rst_n, in, 1, reset; synchronous, active-low.
- flush, in, 1, synchronous clear of all contents.
- wr_valid, in, 1, producer word strobe.
- wr_data, in, LANES*DATA_W, producer word.
- wr_last, in, 1, final word of the group; qualified by wr_valid.
- rd_valid, out, 1, consumer word available.
- rd_ready, in, 1, consumer accept.
- rd_data, out, LANES*DATA_W, consumer word.
- rd_last, out, 1, final word of the current group.
- credit_available, out, 1, at least one free group slot.
- group_count, out, $clog2(DEPTH_GROUPS+1), number of committed, unconsumed groups.
- group_consumed, out, 1, one-cycle pulse when a group drains.
- error, out, 1, sticky error flag.
- error_code, out, 2, sticky cause: bit0 no-credit write, bit1 group overflow.
- stat_groups_in, out, 16, count of committed groups.
- stat_groups_out, out, 16, count of consumed groups.

Function
REQ-003 Storage SHALL be a ring of DEPTH_GROUPS slots, each holding GROUP_WORDS words plus a registered length field.
REQ-004 A slot SHALL be occupied from the accepted first word of a group until the handshake on that group's last word.
REQ-005 credit_available SHALL equal (occupied slots < DEPTH_GROUPS), including the slot currently filling.
REQ-006 The write FSM SHALL have states IDLE, FILL and DROP.
- IDLE with wr_valid and a free slot: store at index 0 and go to FILL.
- IDLE with wr_valid and no free slot: drop the word, set error_code[0], go to DROP.
- If the accepted first word also has wr_last, commit a length-1 group and remain in IDLE.
REQ-007 In FILL, each wr_valid SHALL store the word at the next index.
- wr_last: commit the slot with length = index+1, advance the write slot, go to IDLE.
REQ-008 A write in FILL beyond GROUP_WORDS words SHALL be dropped, set error_code[1], and go to DROP. The partial slot stays occupied and uncommitted until wr_last.
REQ-009 DROP SHALL discard words until wr_valid&&wr_last, then return to IDLE.
- A DROP entered from overflow commits the partial group at length GROUP_WORDS on that wr_last.
- A DROP entered from no-credit commits nothing.
REQ-010 A commit SHALL make the group visible to the reader on the next clock edge; partial groups are never readable.
REQ-011 rd_valid SHALL equal (group_count > 0).
- rd_data is first-word-fall-through: mem[rd_slot][rd_idx].
- rd_last = rd_valid && (rd_idx == len[rd_slot]-1).
REQ-012 A word transfers on rd_valid&&rd_ready; rd_idx then increments. On the last word:
- rd_idx clears, rd_slot advances (mod DEPTH_GROUPS), the slot is freed and group_count decrements.
- group_consumed pulses on the following cycle.
REQ-013 If commit and consume occur in the same cycle, group_count SHALL be unchanged and slot occupancy SHALL be updated consistently.
REQ-014 A slot freed in cycle N SHALL be writable by a first word in cycle N+1 (credit_available updates at the edge).
REQ-015 Slot and index pointers SHALL wrap modulo DEPTH_GROUPS and GROUP_WORDS; stat counters SHALL wrap at 2^16.
REQ-016 error SHALL equal |error_code.
REQ-017 flush SHALL clear all state as reset does, except stat counters; flush dominates simultaneous writes and reads.

Reset
REQ-018 On rst_n=0 at a clock edge, the block SHALL set:
- write FSM to IDLE; all pointers, lengths, occupancy and group_count to 0.
- rd_valid=0, rd_last=0, group_consumed=0, error=0, error_code=0, credit_available=1, stat counters 0.
REQ-019 Reset mid-group SHALL discard the partial group; data memory contents need not be cleared.

Configuration
REQ-020 Macro GSF_STATS_EN: when defined, stat_groups_in increments on each commit and stat_groups_out on each group_consumed. When undefined, both outputs SHALL be tied to 0 and no counter logic is synthesised.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- DEPTH_GROUPS=2, GROUP_WORDS=4, rd_ready=0; write groups of 3 and 4 words -> group_count=2, credit_available=0; rd_valid rises the cycle after the first commit.
- Then rd_ready=1 -> 7 words delivered in order, rd_last on words 3 and 7, two group_consumed pulses, credit_available=1 after the first drain.
- Both slots full; write a 2-word group -> words dropped, error_code=01, group_count stays 2, stored data intact.
- Write 6 words with wr_last on the 6th into an empty unit -> error_code=10, one group of length 4 readable containing words 1-4.
- One slot free; commit and consume in the same cycle -> group_count unchanged, no word lost or duplicated.
- flush asserted mid-FILL with one committed group -> rd_valid=0, group_count=0, error cleared; with GSF_STATS_EN, stat counters retained.
